// File: rtl/adc_acq_sched.sv
// Acquisition scheduler: a period timer starts frames that scan the enabled ADC
// channels through the SPI read core and present captured words on a valid/ready port.
module adc_acq_sched #(
  parameter int DATA_W = 32,
  parameter int NCH    = 4,
  parameter int CH_W   = 2,
  parameter int PER_W  = 16,
  parameter int SETTLE = 8,    // must be >= 1
  parameter int TOUT   = 4095
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              single_i,
  input  logic [PER_W-1:0]  period_i,
  input  logic [NCH-1:0]    ch_mask_i,
  input  logic              clr_i,
  output logic              strr_o,
  input  logic              eor_i,
  input  logic              done_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CH_W-1:0]   ch_o,
  output logic [DATA_W-1:0] sample_o,
  output logic [CH_W-1:0]   sample_ch_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              ovr_o,
  output logic              tout_o
);

  localparam int ST_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int TO_W = $clog2(TOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SETTLE, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_CAPTURE
  } state_t;

  state_t            state_q, state_d;
  logic [PER_W-1:0]  per_cnt_q;
  logic [NCH-1:0]    rem_q;
  logic [ST_W-1:0]   set_cnt_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [DATA_W-1:0] hold_q;
  logic              lock_q;
  logic [CH_W-1:0]   next_ch;
  logic              tick, timeout, capture, ovr_set;

  assign tick    = en_i && (per_cnt_q == '0);
  assign busy_o  = (state_q != S_IDLE);
  assign strr_o  = (state_q == S_START);
  assign capture = (state_q == S_CAPTURE);
  assign ovr_set = (tick && busy_o) || (capture && valid_o && !ready_i);

  // Frame timer: free-runs while enabled, so the first tick lands on the first enabled cycle.
  // NOTE: all sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       per_cnt_q <= '0;
    else if (!en_i)  per_cnt_q <= '0;
    else if (tick)   per_cnt_q <= period_i;
    else             per_cnt_q <= per_cnt_q - PER_W'(1);
  end

  always_comb begin
    next_ch = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (rem_q[k]) next_ch = CH_W'(k);
  end

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      S_IDLE:      if (tick && !lock_q && (ch_mask_i != '0)) state_d = S_SELECT;
      S_SELECT:    state_d = S_SETTLE;
      S_SETTLE:    if (set_cnt_q == '0) state_d = S_START;
      S_START:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!eor_i) state_d = S_WAIT_DONE;
        else if (to_cnt_q == TO_W'(TOUT)) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (done_i) state_d = S_CAPTURE;
        else if (to_cnt_q == TO_W'(TOUT)) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_CAPTURE:   state_d = (en_i && (rem_q != '0)) ? S_SELECT : S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      ch_o      <= '0;
      set_cnt_q <= '0;
      to_cnt_q  <= '0;
      hold_q    <= '0;
      lock_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE:   rem_q <= ch_mask_i;
        S_SELECT: begin
          ch_o          <= next_ch;
          rem_q[next_ch] <= 1'b0;
          set_cnt_q     <= ST_W'(SETTLE - 1);
        end
        S_SETTLE:    set_cnt_q <= set_cnt_q - ST_W'(1);
        S_START:     to_cnt_q  <= '0;
        S_WAIT_BUSY: to_cnt_q  <= to_cnt_q + TO_W'(1);
        S_WAIT_DONE: to_cnt_q  <= to_cnt_q + TO_W'(1);
        default:     ;
      endcase
      // data_i is only guaranteed alongside done_i, so hold it for CAPTURE
      if (state_q == S_WAIT_DONE && done_i) hold_q <= data_i;
      if (!en_i) lock_q <= 1'b0;
      else if (capture && state_d == S_IDLE && single_i) lock_q <= 1'b1;
    end
  end

  // Output register: a capture into a held, unaccepted word is dropped as overrun.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sample_o    <= '0;
      sample_ch_o <= '0;
      valid_o     <= 1'b0;
      ovr_o       <= 1'b0;
      tout_o      <= 1'b0;
    end else begin
      if (capture && (!valid_o || ready_i)) begin
        sample_o    <= hold_q;
        sample_ch_o <= ch_o;
        valid_o     <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      if (ovr_set)    ovr_o <= 1'b1;
      else if (clr_i) ovr_o <= 1'b0;
      if (timeout)    tout_o <= 1'b1;
      else if (clr_i) tout_o <= 1'b0;
    end
  end

endmodule
